lu_minmax_seq: RTL



---
 rtl/lu_minmax_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/lu_minmax_seq.sv
`default_nettype none
// ============================================================================
// lu_minmax_seq : buffers operands and scans them with one shared comparator
//                 for the min/max value and its index.
// Revision 1.0
// ============================================================================
module lu_minmax_seq #(
    parameter  int W     = 3,
    parameter  int DEPTH = 4,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    input  logic          mode,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  result,
    output logic [IW-1:0] result_idx,
    output logic [IW:0]   count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  buf_q [DEPTH];
    logic [W-1:0]  buf_d [DEPTH];
    logic [IW:0]   count_q, count_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  best_q, best_d;
    logic [IW-1:0] best_idx_q, best_idx_d;
    logic [W-1:0]  result_q, result_d;
    logic [IW-1:0] result_idx_q, result_idx_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          accept_ok;
    logic [W-1:0]  cand;
    logic          replace;
    logic          last;

    assign accept_ok = (state_q == ST_IDLE) && (count_q < (IW+1)'(DEPTH)) && !start;
    assign cand      = buf_q[ptr_q];
    // Strict compare keeps the earlier index on ties.
    assign replace   = mode_q ? (cand > best_q) : (cand < best_q);
    assign last      = ({1'b0, ptr_q} == (count_q - (IW+1)'(1)));

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        count_d      = count_q;
        ptr_d        = ptr_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        result_d     = result_q;
        result_idx_d = result_idx_q;
        mode_d       = mode_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d     = mode;
                        best_d     = buf_q[0];
                        best_idx_d = '0;
                        ptr_d      = IW'(1);
                        if (count_q == (IW+1)'(1)) begin
                            state_d      = ST_DONE;
                            done_d       = 1'b1;
                            result_d     = buf_q[0];
                            result_idx_d = '0;
                        end else begin
                            state_d = ST_SCAN;
                            busy_d  = 1'b1;
                        end
                    end
                end else if (in_valid && accept_ok) begin
                    buf_d[count_q[IW-1:0]] = in_data;
                    count_d                = count_q + (IW+1)'(1);
                end
            end

            ST_SCAN: begin
                if (replace) begin
                    best_d     = cand;
                    best_idx_d = ptr_q;
                end
                ptr_d = ptr_q + IW'(1);
                if (last) begin
                    state_d      = ST_DONE;
                    done_d       = 1'b1;
                    result_d     = best_d;
                    result_idx_d = best_idx_d;
                end else begin
                    busy_d = 1'b1;
                end
            end

            ST_DONE: begin
                count_d = '0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            buf_q        <= '{default: '0};
            count_q      <= '0;
            ptr_q        <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            result_q     <= '0;
            result_idx_q <= '0;
            mode_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            count_q      <= count_d;
            ptr_q        <= ptr_d;
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            result_q     <= result_d;
            result_idx_q <= result_idx_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = accept_ok;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign result     = result_q;
    assign result_idx = result_idx_q;
    assign count      = count_q;

endmodule
`default_nettype wire
